// File: rtl/irrigation_scheduler.sv
// Multi-pot watering scheduler: one shared pump, one valve per pot, round-robin service,
// valve lead/drain timing, per-pot cooldown and tank refill with timeout fault.
module irrigation_scheduler #(
  parameter int N_CH         = 4,
  parameter int CH_W         = 2,
  parameter int HUM_W        = 12,
  parameter int DUR_W        = 8,
  parameter int TICK_DIV     = 50000000,
  parameter int VALVE_CYC    = 1000,
  parameter int COOL_S       = 5,
  parameter int REFILL_MAX_S = 120
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH*HUM_W-1:0]   humedad,
  input  logic [N_CH*HUM_W-1:0]   umbral,
  input  logic [N_CH*DUR_W-1:0]   duracion,
  input  logic [N_CH-1:0]         enable,
  input  logic                    lowLevel,
  input  logic                    highLevel,
  output logic                    activarB,
  output logic [N_CH-1:0]         valvula,
  output logic                    activarEV,
  output logic [CH_W-1:0]         canal,
  output logic                    ocupado,
  output logic                    hecho,
  output logic                    alarma_tanque,
  output logic [2:0]              state_dbg
);

  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW    = (VALVE_CYC > 1) ? $clog2(VALVE_CYC) : 1;
  localparam int RW    = $clog2(REFILL_MAX_S + 1);
  localparam int KW    = $clog2(COOL_S + 1);
  localparam int MW    = (RW > KW) ? RW : KW;
  localparam int SEC_W = (DUR_W > MW) ? DUR_W : MW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OPEN   = 3'd1,
    S_PUMP   = 3'd2,
    S_STOP   = 3'd3,
    S_COOL   = 3'd4,
    S_REFILL = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [TW-1:0]     tick_cnt;
  logic              tick;
  logic [CW-1:0]     cyc_cnt, cyc_nxt;
  logic [SEC_W-1:0]  sec_cnt, sec_nxt;
  logic [CH_W-1:0]   ptr, ptr_nxt;
  logic [CH_W-1:0]   canal_nxt;
  logic              abort_flag, abort_nxt;
  logic              hecho_nxt;

  logic [N_CH-1:0]   pending;
  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  int                idx;

  logic [HUM_W-1:0]  hum_sel, umb_sel;
  logic [DUR_W-1:0]  dur_sel;
  logic              stop_cond;

  // Free-running one-second time base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_CH; i++) begin
      pending[i] = enable[i]
                 & (humedad[i*HUM_W +: HUM_W] < umbral[i*HUM_W +: HUM_W])
                 & (duracion[i*DUR_W +: DUR_W] != '0);
    end
  end

  // Round-robin search starting just after the last served channel.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!grant_found && pending[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
  end

  assign hum_sel = humedad[int'(canal)*HUM_W +: HUM_W];
  assign umb_sel = umbral[int'(canal)*HUM_W +: HUM_W];
  assign dur_sel = duracion[int'(canal)*DUR_W +: DUR_W];

  assign stop_cond = (sec_cnt == '0) || (hum_sel >= umb_sel) || !enable[canal] || !lowLevel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cyc_cnt    <= '0;
      sec_cnt    <= '0;
      ptr        <= CH_W'(N_CH - 1);
      canal      <= '0;
      abort_flag <= 1'b0;
      hecho      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cyc_cnt    <= cyc_nxt;
      sec_cnt    <= sec_nxt;
      ptr        <= ptr_nxt;
      canal      <= canal_nxt;
      abort_flag <= abort_nxt;
      hecho      <= hecho_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt;
    sec_nxt   = sec_cnt;
    ptr_nxt   = ptr;
    canal_nxt = canal;
    abort_nxt = abort_flag;
    hecho_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (!lowLevel) begin
          state_nxt = S_REFILL;
          sec_nxt   = '0;
        end else if (grant_found) begin
          state_nxt = S_OPEN;
          canal_nxt = grant_idx;
          ptr_nxt   = grant_idx;
          cyc_nxt   = '0;
        end
      end
      S_OPEN: begin
        if (cyc_cnt == CW'(VALVE_CYC - 1)) begin
          state_nxt = S_PUMP;
          sec_nxt   = SEC_W'(dur_sel);
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      S_PUMP: begin
        if (stop_cond) begin
          state_nxt = S_STOP;
          cyc_nxt   = '0;
          abort_nxt = abort_flag | !lowLevel;
        end else if (tick) begin
          sec_nxt = sec_cnt - 1'b1;
        end
      end
      S_STOP: begin
        // Valve stays open to drain the line before closing.
        if (cyc_cnt == CW'(VALVE_CYC - 1)) begin
          hecho_nxt = 1'b1;
          sec_nxt   = '0;
          state_nxt = abort_flag ? S_REFILL : S_COOL;
        end else begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      S_COOL: begin
        if (tick) begin
          if (sec_cnt == SEC_W'(COOL_S - 1)) begin
            state_nxt = S_IDLE;
          end else begin
            sec_nxt = sec_cnt + 1'b1;
          end
        end
      end
      S_REFILL: begin
        // A full tank wins even if the low sensor still reads empty.
        if (highLevel) begin
          state_nxt = S_IDLE;
          abort_nxt = 1'b0;
        end else if (tick) begin
          if (sec_cnt == SEC_W'(REFILL_MAX_S - 1)) begin
            state_nxt = S_FAULT;
          end else begin
            sec_nxt = sec_cnt + 1'b1;
          end
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    valvula = '0;
    if (state == S_OPEN || state == S_PUMP || state == S_STOP) begin
      valvula[canal] = 1'b1;
    end
  end

  assign activarB      = (state == S_PUMP);
  assign activarEV     = (state == S_REFILL);
  assign ocupado       = (state != S_IDLE) && (state != S_FAULT);
  assign alarma_tanque = (state == S_REFILL) || (state == S_FAULT);
  assign state_dbg     = state;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: directed scenarios plus randomized episodes scored
// against a service-level reference model through an expected queue.
module tb_irrigation_scheduler;
  localparam int N_CH = 4, CH_W = 2, HUM_W = 12, DUR_W = 8;
  localparam int TICK_DIV = 4, VALVE_CYC = 3, COOL_S = 2, REFILL_MAX_S = 6;
  localparam int W = CH_W + DUR_W;

  logic clk, rst;
  logic [N_CH*HUM_W-1:0] humedad, umbral;
  logic [N_CH*DUR_W-1:0] duracion;
  logic [N_CH-1:0] enable;
  logic low_level, high_level;
  logic activar_b, activar_ev, ocupado, hecho, alarma_tanque;
  logic [N_CH-1:0] valvula;
  logic [CH_W-1:0] canal;
  logic [2:0] state_dbg;

  logic [HUM_W-1:0] hum_v[N_CH], umb_v[N_CH];
  logic [DUR_W-1:0] dur_v[N_CH];

  logic [W-1:0] exp_q[$];
  int n_chk, n_fail;
  bit sb_on;
  int cyc;

  irrigation_scheduler #(
    .N_CH(N_CH), .CH_W(CH_W), .HUM_W(HUM_W), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV),
    .VALVE_CYC(VALVE_CYC), .COOL_S(COOL_S), .REFILL_MAX_S(REFILL_MAX_S)
  ) dut (
    .clk(clk), .rst(rst), .humedad(humedad), .umbral(umbral), .duracion(duracion),
    .enable(enable), .lowLevel(low_level), .highLevel(high_level), .activarB(activar_b),
    .valvula(valvula), .activarEV(activar_ev), .canal(canal), .ocupado(ocupado),
    .hecho(hecho), .alarma_tanque(alarma_tanque), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always_comb begin
    humedad  = '0;
    umbral   = '0;
    duracion = '0;
    for (int i = 0; i < N_CH; i++) begin
      humedad[i*HUM_W +: HUM_W]  = hum_v[i];
      umbral[i*HUM_W +: HUM_W]   = umb_v[i];
      duracion[i*DUR_W +: DUR_W] = dur_v[i];
    end
  end

  // Seconds time base: one tick every TICK_DIV cycles counted from reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic bit tick_now();
    return (cyc % TICK_DIV) == (TICK_DIV - 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    for (int i = 0; i < N_CH; i++) begin
      hum_v[i] = 12'd500; umb_v[i] = 12'd200; dur_v[i] = 8'd0;
    end
    enable = '0;
  endtask

  task automatic set_ch(input int c, input int h, input int u, input int d);
    hum_v[c] = HUM_W'(h); umb_v[c] = HUM_W'(u); dur_v[c] = DUR_W'(d);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_for(input int which, input int budget, input string name);
    int n; bit hit;
    n = 0; hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk); n++;
      case (which)
        0: hit = activar_b;
        1: hit = (valvula != '0);
        default: hit = activar_ev;
      endcase
    end
    check(name, 32'(hit), 32'd1);
  endtask

  task automatic wait_hechos(input int n, input int budget);
    int got, c;
    got = 0; c = 0;
    while (got < n && c < budget) begin
      @(negedge clk); c++;
      if (hecho) got++;
    end
    check("hecho_count", got, n);
  endtask

  // Counts valve-open cycles from the current cycle up to the hecho pulse.
  task automatic drain_count(output int cnt);
    int c;
    cnt = 0; c = 0;
    while (!hecho && c < 30) begin
      if (valvula != '0) cnt++;
      @(negedge clk); c++;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  bit in_svc, last_t, aligned;
  int pre, post, plen;
  logic [DUR_W-1:0] ptk;
  logic [CH_W-1:0] svc_ch;

  always @(negedge clk) begin
    logic [W-1:0] e;
    bit t;
    if (rst) begin
      in_svc = 1'b0;
    end else begin
      t = tick_now();
      check("valve_onehot", 32'($countones(valvula) <= 1), 32'd1);
      check("pump_ev_exclusive", 32'(activar_b & activar_ev), 32'd0);
      if (activar_b) check("pump_one_valve", $countones(valvula), 32'd1);
      if (valvula != '0) begin
        if (!in_svc) begin
          in_svc = 1'b1; pre = 0; post = 0; plen = 0; ptk = '0; last_t = 1'b0; aligned = 1'b0;
          svc_ch = '0;
          for (int i = 0; i < N_CH; i++) if (valvula[i]) svc_ch = CH_W'(i);
        end
        if (activar_b) begin
          aligned = last_t; last_t = t; plen++;
          if (t) ptk++;
        end else if (plen == 0) pre++;
        else post++;
      end
      if (hecho) begin
        if (sb_on) begin
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_hecho: got channel %0d with nothing expected", svc_ch);
          end else begin
            e = exp_q.pop_front();
            check("svc_chan_ticks", {svc_ch, ptk}, e);
            check("valve_lead_cycles", pre, VALVE_CYC);
            check("valve_drain_cycles", post, VALVE_CYC);
            check("pump_end_after_tick", 32'(aligned), 32'd1);
            check("canal_out", canal, svc_ch);
          end
        end
        in_svc = 1'b0;
      end
    end
  end

  // ---------------- reference model (service level) ----------------
  int mptr;

  function automatic bit is_pending(input int c);
    return enable[c] && (hum_v[c] < umb_v[c]) && (dur_v[c] != 0);
  endfunction

  task automatic random_episode();
    int n_svc, found;
    bit any;
    for (int i = 0; i < N_CH; i++) begin
      int u, h;
      u = $urandom_range(0, 4095);
      case ($urandom_range(0, 3))
        0: h = u;
        1: h = (u > 0) ? u - 1 : 0;
        default: h = $urandom_range(0, 4095);
      endcase
      set_ch(i, h, u, $urandom_range(0, 3));
      enable[i] = ($urandom_range(0, 3) != 0);
    end
    any = 1'b0;
    for (int i = 0; i < N_CH; i++) if (is_pending(i)) any = 1'b1;
    if (!any) begin
      repeat (20) @(negedge clk);
      check("idle_no_pending", {ocupado, valvula}, 32'd0);
    end else begin
      n_svc = $urandom_range(1, 5);
      for (int s = 0; s < n_svc; s++) begin
        found = -1;
        for (int k = 1; k <= N_CH; k++)
          if (found < 0 && is_pending((mptr + k) % N_CH)) found = (mptr + k) % N_CH;
        mptr = found;
        exp_q.push_back({CH_W'(found), dur_v[found]});
      end
      wait_hechos(n_svc, 60 * n_svc);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, tk, n;
    n_chk = 0; n_fail = 0; sb_on = 1'b1;
    rst = 1'b1; low_level = 1'b1; high_level = 1'b0;
    clear_inputs();
    #1;
    check("reset_outputs", {activar_b, valvula, activar_ev, canal, ocupado, hecho, alarma_tanque}, 32'd0);

    // Channel 1 dry, duration 3, then cooldown length
    set_ch(1, 100, 200, 3); enable = 4'b0010;
    exp_q.push_back({2'd1, 8'd3});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_hechos(1, 100);
    enable = '0;
    tk = 0; n = 0;
    while (ocupado && n < 50) begin
      if (tick_now()) tk++;
      @(negedge clk); n++;
    end
    check("cooldown_ticks", tk, COOL_S);

    // Channels 0 and 2 continuously dry: alternating service from reset
    do_reset();
    set_ch(0, 100, 200, 1); set_ch(2, 50, 300, 1); enable = 4'b0101;
    exp_q.push_back({2'd0, 8'd1}); exp_q.push_back({2'd2, 8'd1});
    exp_q.push_back({2'd0, 8'd1}); exp_q.push_back({2'd2, 8'd1});
    wait_hechos(4, 200);
    clear_inputs();
    repeat (20) @(negedge clk);

    // Channel 3 wet mid-pump
    sb_on = 1'b0;
    set_ch(3, 100, 200, 5); enable = 4'b1000;
    wait_for(0, 100, "ch3_pump_start");
    repeat (3) @(negedge clk);
    hum_v[3] = 12'd250;
    @(negedge clk);
    check("wet_stop_pump_off", {activar_b, valvula}, {1'b0, 4'b1000});
    drain_count(cnt);
    check("wet_stop_drain", cnt, VALVE_CYC);
    check("wet_stop_cooldown", {activar_ev, alarma_tanque, ocupado, valvula}, {3'b001, 4'b0000});
    clear_inputs();
    repeat (20) @(negedge clk);

    // Tank low mid-pump: abort, refill, resume
    set_ch(0, 100, 200, 5); enable = 4'b0001;
    wait_for(0, 100, "ch0_pump_start");
    repeat (2) @(negedge clk);
    low_level = 1'b0;
    @(negedge clk);
    check("low_stop_pump_off", {activar_b, valvula}, {1'b0, 4'b0001});
    drain_count(cnt);
    check("low_stop_drain", cnt, VALVE_CYC);
    check("low_stop_refill", {activar_ev, alarma_tanque, ocupado}, 32'b111);
    repeat (3) @(negedge clk);
    check("refill_holding", {activar_ev, alarma_tanque}, 32'b11);
    high_level = 1'b1; low_level = 1'b1;
    @(negedge clk);
    check("refill_done", {activar_ev, alarma_tanque}, 32'b00);
    high_level = 1'b0;
    wait_for(1, 20, "resume_valve_open");
    check("resume_channel", valvula, 4'b0001);
    wait_hechos(1, 200);
    clear_inputs();
    repeat (20) @(negedge clk);

    // Refill timeout into FAULT
    low_level = 1'b0;
    wait_for(2, 10, "refill_start");
    tk = 0; n = 0;
    while (activar_ev && n < 100) begin
      if (tick_now()) tk++;
      @(negedge clk); n++;
    end
    check("refill_timeout_ticks", tk, REFILL_MAX_S);
    check("fault_outputs", {activar_b, valvula, activar_ev, ocupado, alarma_tanque}, 32'b0000_0001);
    low_level = 1'b1;
    repeat (10) @(negedge clk);
    check("fault_sticky", {ocupado, alarma_tanque}, 32'b01);
    #2 rst = 1'b1;
    #1 check("fault_async_clear", alarma_tanque, 32'd0);

    // Reset mid-pump; channel 0 served first afterwards
    set_ch(1, 100, 200, 5); enable = 4'b0010;
    @(negedge clk); rst = 1'b0;
    wait_for(0, 100, "ch1_pump_start");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_pump", {activar_b, valvula, ocupado}, 32'd0);
    set_ch(0, 100, 200, 1); set_ch(2, 100, 200, 1); enable = 4'b0111;
    @(negedge clk); rst = 1'b0;
    wait_for(1, 20, "post_reset_valve");
    check("post_reset_first", {canal, valvula}, {2'd0, 4'b0001});
    clear_inputs();

    // Randomized episodes against the reference model
    do_reset();
    sb_on = 1'b1; mptr = N_CH - 1;
    for (int ep = 0; ep < 25; ep++) random_episode();
    clear_inputs();
    repeat (30) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Parametrised successor to the single-pot watering path (activation check + pump + electrovalve).
- Serves N_CH pots from one shared pump: one valve per pot, round-robin arbitration, per-pot humidity threshold and watering duration.
- Controls tank refill with a timeout fault.
- Sits between the decoder outputs (humidity, thresholds, durations) and the actuator pins; its alarm output feeds the melody alarm modules.

Parameters:
- N_CH, 4, number of pots/valves.
- CH_W, 2, width of channel index (≥ clog2(N_CH)).
- HUM_W, 12, humidity word width.
- DUR_W, 8, watering duration width, in seconds.
- TICK_DIV, 50000000, clk cycles per 1 s tick.
- VALVE_CYC, 1000, clk cycles a valve stays open before the pump starts and after it stops.
- COOL_S, 5, seconds of cooldown after each watering.
- REFILL_MAX_S, 120, refill timeout in seconds.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-high reset.
- humedad, in, N_CH*HUM_W, packed humidity; channel i at [i*HUM_W +: HUM_W].
- umbral, in, N_CH*HUM_W, packed dry thresholds.
- duracion, in, N_CH*DUR_W, packed watering seconds.
- enable, in, N_CH, per-channel enable.
- lowLevel, in, 1, 1 = tank at/above 5 % mark.
- highLevel, in, 1, 1 = tank at/above 90 % mark.
- activarB, out, 1, pump on.
- valvula, out, N_CH, one-hot valve open.
- activarEV, out, 1, refill electrovalve on.
- canal, out, CH_W, channel being served.
- ocupado, out, 1, high in every state except IDLE and FAULT.
- hecho, out, 1, one-cycle pulse when a watering completes.
- alarma_tanque, out, 1, high in REFILL and FAULT.

Behaviour:
- Reset (async):
  - Outputs: all outputs 0.
  - State: IDLE.
  - Round-robin pointer: N_CH-1, so channel 0 is checked first.
  - Counters: tick counter and all other counters cleared.
- Tick: free-running counter 0..TICK_DIV-1. `tick` pulses one cycle when the count equals TICK_DIV-1.
- Inputs are sampled every cycle; there are no input registers.
- Dry test: channel i is pending when `enable[i] & (humedad_i < umbral_i) & (duracion_i != 0)`. The comparison is unsigned.
- IDLE:
  - If lowLevel == 0, go to REFILL. Refill takes priority over any pending channel.
  - Else, if any channel is pending: choose the first pending channel searching ptr+1, ptr+2, … modulo N_CH. Set canal and ptr to it, clear the cycle counter, go to OPEN.
- OPEN:
  - valvula[canal] = 1, activarB = 0.
  - After VALVE_CYC cycles, load the seconds counter with duracion_canal and go to PUMP.
- PUMP:
  - activarB = 1, valvula[canal] = 1.
  - Seconds counter decrements on each tick.
  - Stop condition, checked every cycle: counter == 0, OR humedad_canal >= umbral_canal, OR enable[canal] == 0, OR lowLevel == 0.
  - On stop, activarB goes 0 in the next cycle; go to STOP.
  - Record an abort flag when lowLevel == 0 caused the stop.
- STOP:
  - activarB = 0, valvula[canal] still 1 for VALVE_CYC cycles to drain.
  - Then valvula = 0 and hecho pulses for 1 cycle.
  - Go to REFILL if the abort flag is set, else to COOLDOWN.
- COOLDOWN: all actuators off. After COOL_S ticks, go to IDLE.
- REFILL:
  - activarEV = 1 and alarma_tanque = 1; seconds counter counts ticks.
  - highLevel == 1: activarEV goes 0 next cycle, clear abort flag, go to IDLE.
  - Count reaches REFILL_MAX_S first: go to FAULT.
- FAULT:
  - All actuators 0, alarma_tanque = 1.
  - Exits only on rst.
- Invariants:
  - valvula is one-hot or zero.
  - activarB = 1 only while exactly one valve is open.
  - activarB and activarEV are never 1 in the same cycle.
- Simultaneous events:
  - Pending channels arriving during a service wait; they are arbitrated in the next IDLE.
  - highLevel == 1 together with lowLevel == 0 (sensor conflict): treated as refill-complete, since highLevel wins in REFILL. IDLE then re-enters REFILL next cycle while lowLevel stays 0.

Test Plan (TICK_DIV=4, VALVE_CYC=3, COOL_S=2, REFILL_MAX_S=6, N_CH=4):
- Channel 1 dry (humedad 100 < umbral 200), duracion 3, tank ok → valvula=0010 for 3 cycles, then activarB=1 for 3 ticks (~12 cycles), valve held 3 more cycles, hecho pulse, cooldown 8 cycles, then ocupado=0.
- Channels 0 and 2 both dry continuously → service order 0, 2, 0, 2; canal never repeats while the other is still pending.
- Channel 3 pumping, humedad_3 raised to 250 ≥ umbral 200 mid-pump → activarB drops next cycle, STOP drain, hecho pulses, COOLDOWN.
- lowLevel → 0 mid-pump → pump off next cycle, drain, hecho, then activarEV=1 and alarma_tanque=1; highLevel=1 → activarEV=0, return to IDLE and resume serving.
- lowLevel=0, highLevel never asserted → activarEV=1 for 6 ticks, then FAULT: all actuators 0, alarma_tanque=1 held; rst clears it.
- rst asserted mid-PUMP → activarB, valvula, ocupado go 0 asynchronously; after release, channel 0 is served first.
